alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised sequential ALU for the ARM datapath. It is the next generation of the single-cycle four-operation ALU. It widens the opcode to eight operations and adds an iterative multiplier and an iterative unsigned divider. Every result and every NZCV flag is registered, and a start/busy/done handshake lets the control unit stall while a multi-cycle operation runs.

## Interface
- N, default 32: operand and result width; N ≥ 4.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request; sampled only in IDLE.
- opcode_i  in  3  operation select; sampled with start_i.
- a_i  in  N  operand A; sampled with start_i.
- b_i  in  N  operand B; sampled with start_i.
- busy_o  out  1  high whenever the block is not in IDLE.
- done_o  out  1  one-cycle pulse; result_o and ALUFlags are valid from this cycle.
- result_o  out  N  registered result.
- ALUFlags  out  4  registered flags {N,Z,C,V}, bit 3 = N.

## Operation
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a−b.
  - 010 AND.
  - 011 ORR.
  - 100 EOR.
  - 101 LSL: a << b[log2(N)−1:0].
  - 110 MUL: low N bits of a×b, unsigned.
  - 111 UDIV: a/b, unsigned quotient.
- States are IDLE, ITER and DONE.
- IDLE:
  - Leave IDLE only when start_i=1.
  - Single-cycle opcodes (000–101) go directly to DONE; the result and flags are computed and registered on the same edge.
  - MUL and UDIV latch the operands, clear the accumulator/remainder, load the iteration counter with N−1, and go to ITER.
- ITER:
  - MUL does one shift-add step per cycle on multiplier bit i, LSB first.
  - UDIV does one restoring step per cycle, MSB first, with a 2N-bit working remainder.
  - The counter decrements each cycle. When the counter is 0 at the edge, the final result and flags are registered and the state moves to DONE. ITER therefore lasts exactly N cycles.
- DONE:
  - done_o=1 for exactly this one cycle.
  - The next state is always IDLE. start_i is ignored in DONE.
- Flag rules, applied to every opcode:
  - N = result[N−1].
  - Z = (result == 0).
- C flag:
  - ADD: carry out of bit N−1.
  - SUB: NOT borrow, i.e. 1 when a ≥ b unsigned.
  - LSL: last bit shifted out; 0 if the shift amount is 0.
  - All other opcodes: 0.
- V flag:
  - ADD/SUB: signed overflow (operand signs agree and result sign differs; for SUB, b is inverted first).
  - UDIV: 1 on divide by zero.
  - All other opcodes: 0.
- Divide by zero:
  - Still takes the full N ITER cycles.
  - result_o = all ones, V=1, C=0; N and Z follow the result.
- result_o and ALUFlags hold their value from the last DONE until the next DONE. They do not change during ITER.
- start_i while busy_o=1 is ignored and is not queued. Inputs may change freely after the sampling edge.

## Timing
- Reset values: state IDLE, busy_o=0, done_o=0, result_o=0, ALUFlags=4'b0000, counter=0.
- Reset mid-operation: rst_i=1 at any edge aborts the operation and restores the reset values. No done_o pulse is produced.
- Latency is counted from the edge that samples start_i=1 to the first cycle with done_o=1:
  - Single-cycle opcodes: 1 cycle.
  - MUL/UDIV: N+1 cycles.
- busy_o follows the state: 1 in ITER and DONE, 0 in IDLE.
- Throughput: a new start_i is accepted at the earliest one cycle after done_o. The back-to-back period is 2 cycles for single-cycle ops and N+2 cycles for MUL/UDIV.
- rst_i and start_i high together: reset wins.

## Test plan
- Reset then ADD, N=32, a=1, b=10 → done_o one cycle after start, result=11, flags 0000. With a=0x7FFFFFFF, b=1 → result=0x80000000, flags N=1, V=1 (1001).
- SUB, a=10, b=10 → result=0, flags 0110 (Z, C). With a=1, b=10 → result=0xFFFFFFF7, flags 1000.
- AND/ORR/EOR/LSL, a=0xF0F0F0F0, b=0x0FF00FF0 → results 0x00F000F0, 0xFFF0FFF0, 0xFF00FF00. LSL with a=0x80000001, b=1 → result=2, C=1.
- MUL, a=123456, b=1000 → busy_o high, done_o exactly 33 cycles after start, result=123456000. With a=0xFFFFFFFF, b=2 → result=0xFFFFFFFE, flags 1000.
- UDIV, a=100, b=7 → result=14 after 33 cycles. With a=5, b=0 → result=0xFFFFFFFF, flags 1001.
- MUL started, start_i pulsed with opcode ADD at cycle 5 → ignored, MUL result is unchanged. rst_i asserted at cycle 10 → busy_o=0, result_o=0 the next cycle, and no done_o pulse.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// ---------------------------------------------------------------------------
// alu_multicycle_if
// Handshake and data bundle between the control unit and the multi-cycle ALU.
//   start_i   request, sampled by the ALU only while it is idle
//   opcode_i  operation select, sampled with start_i
//   a_i, b_i  operands, sampled with start_i
//   busy_o    high whenever the ALU is not idle
//   done_o    one-cycle pulse marking a fresh result
//   result_o  registered result
//   ALUFlags  registered {N,Z,C,V}
// The master modport is the requester (control unit), the slave is the ALU.
// ---------------------------------------------------------------------------
interface alu_multicycle_if #(
    parameter int N = 32
);
    logic         start_i;
    logic [2:0]   opcode_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] result_o;
    logic [3:0]   ALUFlags;

    modport master (
        output start_i, opcode_i, a_i, b_i,
        input  busy_o, done_o, result_o, ALUFlags
    );

    modport slave (
        input  start_i, opcode_i, a_i, b_i,
        output busy_o, done_o, result_o, ALUFlags
    );
endinterface

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
// Sequential eight-operation ALU with an iterative shift-add multiplier and an
// iterative restoring unsigned divider. All results and NZCV flags are
// registered; a start/busy/done handshake lets the control unit stall.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    alu_multicycle_if slave (start/opcode/operands in,
//          busy/done/result/flags out)
// ---------------------------------------------------------------------------
module alu_multicycle #(
    parameter int N = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    alu_multicycle_if.slave       bus
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic           isDiv_q, isDiv_d;
    logic [N-1:0]   opA_q, opA_d;
    logic [N-1:0]   opB_q, opB_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [2*N-1:0] rem_q, rem_d;
    logic [N-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d;

    logic [N-1:0]   aluRes;
    logic           aluC, aluV;
    logic [N:0]     addSum;
    logic [N:0]     shWide;
    logic [N-1:0]   accNext;
    logic [2*N:0]   shifted;
    logic [N:0]     trial;
    logic [2*N-1:0] remNext;
    logic [N-1:0]   iterRes;

    // Single-cycle datapath for opcodes 000-101. The shift is done one bit
    // wider than the operand so the top bit is the last bit shifted out; a
    // zero shift leaves it clear, which is exactly the required C behaviour.
    always_comb begin
        aluRes = '0;
        aluC   = 1'b0;
        aluV   = 1'b0;
        addSum = '0;
        shWide = {1'b0, bus.a_i} << bus.b_i[SW-1:0];
        case (bus.opcode_i)
            3'b000: begin
                addSum = {1'b0, bus.a_i} + {1'b0, bus.b_i};
                aluRes = addSum[N-1:0];
                aluC   = addSum[N];
                aluV   = (bus.a_i[N-1] == bus.b_i[N-1]) && (aluRes[N-1] != bus.a_i[N-1]);
            end
            3'b001: begin
                addSum = {1'b0, bus.a_i} + {1'b0, ~bus.b_i} + (N+1)'(1);
                aluRes = addSum[N-1:0];
                aluC   = addSum[N];
                aluV   = (bus.a_i[N-1] == ~bus.b_i[N-1]) && (aluRes[N-1] != bus.a_i[N-1]);
            end
            3'b010: aluRes = bus.a_i & bus.b_i;
            3'b011: aluRes = bus.a_i | bus.b_i;
            3'b100: aluRes = bus.a_i ^ bus.b_i;
            3'b101: begin
                aluRes = shWide[N-1:0];
                aluC   = shWide[N];
            end
            default: aluRes = '0;
        endcase
    end

    // One iteration step of each multi-cycle unit. The multiplier adds the
    // left-shifting multiplicand whenever the right-shifting multiplier LSB is
    // set. The divider shifts the 2N-bit remainder left and subtracts the
    // divisor from the upper half (with one extra bit so no carry is lost);
    // a divisor of zero never borrows, so the quotient naturally becomes
    // all ones.
    always_comb begin
        accNext = acc_q + (opB_q[0] ? opA_q : '0);
        shifted = {rem_q, 1'b0};
        trial   = shifted[2*N:N] - {1'b0, opB_q};
        if (!trial[N]) begin
            remNext = {trial[N-1:0], shifted[N-1:1], 1'b1};
        end else begin
            remNext = shifted[2*N-1:0];
        end
        iterRes = isDiv_q ? remNext[N-1:0] : accNext;
    end

    // Next-state logic: IDLE accepts a request, ITER runs N steps counting
    // down from N-1, DONE is a single pulse cycle that always returns to IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        isDiv_d  = isDiv_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (bus.opcode_i[2:1] == 2'b11) begin
                        state_d = ITER;
                        isDiv_d = bus.opcode_i[0];
                        cnt_d   = SW'(N - 1);
                        opA_d   = bus.a_i;
                        opB_d   = bus.b_i;
                        acc_d   = '0;
                        rem_d   = {{N{1'b0}}, bus.a_i};
                    end else begin
                        state_d  = DONE;
                        result_d = aluRes;
                        flags_d  = {aluRes[N-1], aluRes == '0, aluC, aluV};
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q - 1'b1;
                acc_d = accNext;
                rem_d = remNext;
                if (!isDiv_q) begin
                    opA_d = opA_q << 1;
                    opB_d = opB_q >> 1;
                end
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = iterRes;
                    flags_d  = {iterRes[N-1], iterRes == '0, 1'b0, isDiv_q && (opB_q == '0)};
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            isDiv_q  <= 1'b0;
            opA_q    <= '0;
            opB_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            isDiv_q  <= isDiv_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.busy_o   = (state_q != IDLE);
    assign bus.done_o   = (state_q == DONE);
    assign bus.result_o = result_q;
    assign bus.ALUFlags = flags_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle
// Self-checking bench for alu_multicycle: directed cases followed by random
// operations, all compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_multicycle;
    localparam int N = 32;

    logic clk_i = 1'b0;
    logic rst_i;

    int totalCount = 0;
    int badCount   = 0;

    logic [N-1:0] lastResult = '0;
    logic [3:0]   lastFlags  = 4'b0000;

    always #5 clk_i = ~clk_i;

    alu_multicycle_if #(.N(N)) bus ();

    alu_multicycle #(.N(N)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Reference model: {flags, result} from plain arithmetic on the operands.
    function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c;
        logic        v;
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] p;
        int          sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        v  = 1'b0;
        sh = int'(b[4:0]);
        case (op)
            3'd0: begin
                r = a + b;
                c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a << sh;
                c = (sh == 0) ? 1'b0 : a[32 - sh];
            end
            3'd6: begin
                p = 64'(a) * 64'(b);
                r = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    r = 32'hFFFF_FFFF;
                    v = 1'b1;
                end else begin
                    r = a / b;
                end
            end
        endcase
        return {r[31], r == 32'd0, c, v, r};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCount++;
        assert (observed === expected) else begin
            badCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single cycle, then scrambles the inputs to
    // show they are only sampled on the accepting edge. Returns on the
    // negedge following that edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        bus.start_i  = 1'b1;
        bus.opcode_i = op;
        bus.a_i      = a;
        bus.b_i      = b;
        @(negedge clk_i);
        bus.start_i  = 1'b0;
        bus.opcode_i = 3'($urandom);
        bus.a_i      = $urandom;
        bus.b_i      = $urandom;
    endtask

    task automatic waitDone(inout int cycles);
        while (bus.done_o !== 1'b1 && cycles < 60) begin
            @(negedge clk_i);
            cycles++;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [35:0] exp;
        int          lat;
        int          cycles;
        exp = model(op, a, b);
        lat = (op >= 3'd6) ? N + 1 : 1;
        applyStimulus(op, a, b);
        cycles = 1;
        if (lat > 1) begin
            checkOutput({tag, " busy"}, 64'(bus.busy_o), 64'd1);
            checkOutput({tag, " hold"}, {28'd0, bus.ALUFlags, bus.result_o}, {28'd0, lastFlags, lastResult});
        end
        waitDone(cycles);
        checkOutput({tag, " latency"}, 64'(cycles), 64'(lat));
        checkOutput({tag, " result"}, 64'(bus.result_o), 64'(exp[31:0]));
        checkOutput({tag, " flags"}, 64'(bus.ALUFlags), 64'(exp[35:32]));
        @(negedge clk_i);
        checkOutput({tag, " idle"}, 64'({bus.busy_o, bus.done_o}), 64'd0);
        lastResult = exp[31:0];
        lastFlags  = exp[35:32];
    endtask

    initial begin
        logic [35:0] exp;
        int          cycles;
        logic        sawDone;
        logic [2:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_i        = 1'b1;
        bus.start_i  = 1'b0;
        bus.opcode_i = 3'd0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset state", {bus.busy_o, bus.done_o, bus.ALUFlags, bus.result_o}, 64'd0);
        rst_i = 1'b0;

        runOp("add small", 3'd0, 32'd1, 32'd10);
        runOp("add ovf", 3'd0, 32'h7FFF_FFFF, 32'd1);
        runOp("add carry", 3'd0, 32'hFFFF_FFFF, 32'd1);
        runOp("sub zero", 3'd1, 32'd10, 32'd10);
        runOp("sub neg", 3'd1, 32'd1, 32'd10);
        runOp("sub ovf", 3'd1, 32'h8000_0000, 32'd1);
        runOp("and", 3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        runOp("orr", 3'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        runOp("eor", 3'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        runOp("lsl carry", 3'd5, 32'h8000_0001, 32'd1);
        runOp("lsl zero amt", 3'd5, 32'h8000_0001, 32'h0000_0020);
        runOp("lsl 31", 3'd5, 32'h0000_0003, 32'd31);
        runOp("mul", 3'd6, 32'd123456, 32'd1000);
        runOp("mul wrap", 3'd6, 32'hFFFF_FFFF, 32'd2);
        runOp("udiv", 3'd7, 32'd100, 32'd7);
        runOp("udiv by zero", 3'd7, 32'd5, 32'd0);
        runOp("udiv max", 3'd7, 32'hFFFF_FFFF, 32'h8000_0000);

        // A start pulse during a multiply must be ignored.
        exp = model(3'd6, 32'd54321, 32'd777);
        applyStimulus(3'd6, 32'd54321, 32'd777);
        cycles = 1;
        repeat (3) begin
            @(negedge clk_i);
            cycles++;
        end
        bus.start_i  = 1'b1;
        bus.opcode_i = 3'd0;
        bus.a_i      = 32'd1;
        bus.b_i      = 32'd2;
        @(negedge clk_i);
        cycles++;
        bus.start_i = 1'b0;
        waitDone(cycles);
        checkOutput("ignore latency", 64'(cycles), 64'(N + 1));
        checkOutput("ignore result", 64'(bus.result_o), 64'(exp[31:0]));
        @(negedge clk_i);
        checkOutput("ignore no requeue", 64'({bus.busy_o, bus.done_o}), 64'd0);

        // Reset in the middle of a multiply aborts it without a done pulse.
        applyStimulus(3'd6, 32'd99, 32'd99);
        repeat (8) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("abort state", {bus.busy_o, bus.done_o, bus.ALUFlags, bus.result_o}, 64'd0);
        rst_i   = 1'b0;
        sawDone = 1'b0;
        repeat (N + 4) begin
            @(negedge clk_i);
            if (bus.done_o === 1'b1) sawDone = 1'b1;
        end
        checkOutput("abort no done", 64'(sawDone), 64'd0);
        lastResult = '0;
        lastFlags  = 4'b0000;

        // Reset and start together: reset wins.
        @(negedge clk_i);
        rst_i        = 1'b1;
        bus.start_i  = 1'b1;
        bus.opcode_i = 3'd0;
        bus.a_i      = 32'd3;
        bus.b_i      = 32'd4;
        @(negedge clk_i);
        checkOutput("reset beats start", {bus.busy_o, bus.done_o, bus.ALUFlags, bus.result_o}, 64'd0);
        rst_i       = 1'b0;
        bus.start_i = 1'b0;

        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if (op == 3'd7 && (i % 3) == 0) rb = 32'($urandom_range(0, 15));
            if (op == 3'd6 && (i % 2) == 0) rb = 32'($urandom_range(0, 65535));
            runOp($sformatf("rand%0d op%0d", i, op), op, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end
endmodule
